// File: rtl/ob_mk_table_sched_if.sv
// ============================================================================
//  ob_mk_table_sched_if
//  Requester-side bundle of the book-side table scheduler: head ops from the
//  match engine, cancels and tail inserts from command ingress, and the
//  registered cancel response.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface ob_mk_table_sched_if #(
  parameter int UID_W = 8,
  parameter int TBL_W = 40
);
  // Head op channel (match engine)
  logic             hd_req_vld;
  logic [1:0]       hd_req_op;
  logic [TBL_W-1:0] hd_req_tbl;
  logic             hd_req_rdy;
  // Cancel channel (command ingress)
  logic             cn_req_vld;
  logic [UID_W-1:0] cn_req_uid;
  logic             cn_req_rdy;
  // Tail insert channel (command ingress)
  logic             in_req_vld;
  logic [TBL_W-1:0] in_req_tbl;
  logic             in_req_rdy;
  // Cancel response
  logic             cn_rsp_vld;
  logic             cn_rsp_hit;
  logic [TBL_W-1:0] cn_rsp_tbl;

  modport master (
    output hd_req_vld, hd_req_op, hd_req_tbl,
    output cn_req_vld, cn_req_uid,
    output in_req_vld, in_req_tbl,
    input  hd_req_rdy, cn_req_rdy, in_req_rdy,
    input  cn_rsp_vld, cn_rsp_hit, cn_rsp_tbl
  );

  modport slave (
    input  hd_req_vld, hd_req_op, hd_req_tbl,
    input  cn_req_vld, cn_req_uid,
    input  in_req_vld, in_req_tbl,
    output hd_req_rdy, cn_req_rdy, in_req_rdy,
    output cn_rsp_vld, cn_rsp_hit, cn_rsp_tbl
  );
endinterface

`default_nettype wire

// File: rtl/ob_mk_table_sched.sv
// ============================================================================
//  ob_mk_table_sched
//  Single-port scheduler in front of one order-book table (one side).
//  Grants at most one table modification per cycle (head > cancel > insert,
//  with an anti-starvation override for inserts), gates ops on the registered
//  full/empty status, returns registered cancel responses and runs a flush
//  sequence that pops the table until empty.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ob_mk_table_sched #(
  parameter int STARVE_MAX = 8,   // legal range 1..255
  parameter int UID_W      = 8,
  parameter int TBL_W      = 40   // uid occupies the top UID_W bits
) (
  input  logic                clk,
  input  logic                rst,
  ob_mk_table_sched_if.slave  req,
  input  logic                flush_req_i,
  output logic                flush_busy_o,
  output logic                flush_done_o,
  output logic                head_pop_o,
  output logic                head_push_o,
  output logic [TBL_W-1:0]    head_push_tbl_o,
  output logic                head_upt_o,
  output logic [TBL_W-1:0]    head_upt_tbl_o,
  output logic                insert_o,
  output logic [TBL_W-1:0]    insert_tbl_o,
  output logic                cancel_o,
  output logic [UID_W-1:0]    cancel_uid_o,
  input  logic                cancel_hit_w_i,
  input  logic [TBL_W-1:0]    cancel_hit_tbl_w_i,
  input  logic                full_w_i,
  input  logic                empty_w_i
);

  localparam logic [1:0] OP_POP     = 2'd0;
  localparam logic [1:0] OP_PUSH    = 2'd1;
  localparam logic [1:0] OP_UPT     = 2'd2;
  localparam logic [7:0] STARVE_LIM = STARVE_MAX[7:0];

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             full_q, empty_q;
  logic [7:0]       starve_q, starve_d;
  logic             rsp_vld_q, rsp_hit_q;
  logic [TBL_W-1:0] rsp_tbl_q;

  logic hd_elig, in_elig;
  logic gnt_hd, gnt_cn, gnt_in;
  logic flush_pop, flush_done;
  logic live;

  // Head eligibility depends on the op: pop/update need entries, push needs room
  always_comb begin
    hd_elig = 1'b0;
    case (req.hd_req_op)
      OP_POP, OP_UPT: hd_elig = req.hd_req_vld && !empty_q;
      OP_PUSH:        hd_elig = req.hd_req_vld && !full_q;
      default:        hd_elig = 1'b0;   // reserved op is never granted
    endcase
  end

  assign in_elig = req.in_req_vld && !full_q;

  // FSM next state plus RUN-state arbitration; one grant at most per cycle
  always_comb begin
    state_d    = state_q;
    gnt_hd     = 1'b0;
    gnt_cn     = 1'b0;
    gnt_in     = 1'b0;
    flush_pop  = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_RUN: begin
        if (starve_q == STARVE_LIM && in_elig) gnt_in = 1'b1;
        else if (hd_elig)                      gnt_hd = 1'b1;
        else if (req.cn_req_vld)               gnt_cn = 1'b1;
        else if (in_elig)                      gnt_in = 1'b1;
        // the grant above still completes in the cycle the flush starts
        if (flush_req_i) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_pop = !empty_q;
        if (empty_q) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Insert starvation counter: counts lost arbitrations of an eligible insert
  always_comb begin
    starve_d = starve_q;
    if (!req.in_req_vld || gnt_in)
      starve_d = '0;
    else if (state_q == S_RUN && in_elig && starve_q != STARVE_LIM)
      starve_d = starve_q + 8'd1;
  end

  // Every handshake and table pin is forced low while reset is asserted
  assign live = !rst;

  assign req.hd_req_rdy = live && gnt_hd;
  assign req.cn_req_rdy = live && gnt_cn;
  assign req.in_req_rdy = live && gnt_in;

  assign head_pop_o      = live && ((gnt_hd && req.hd_req_op == OP_POP) || flush_pop);
  assign head_push_o     = live && gnt_hd && req.hd_req_op == OP_PUSH;
  assign head_upt_o      = live && gnt_hd && req.hd_req_op == OP_UPT;
  assign insert_o        = live && gnt_in;
  assign cancel_o        = live && gnt_cn;
  assign head_push_tbl_o = head_push_o ? req.hd_req_tbl : '0;
  assign head_upt_tbl_o  = head_upt_o  ? req.hd_req_tbl : '0;
  assign insert_tbl_o    = insert_o    ? req.in_req_tbl : '0;
  assign cancel_uid_o    = cancel_o    ? req.cn_req_uid : '0;

  assign flush_busy_o = (state_q != S_RUN);
  assign flush_done_o = live && flush_done;

  assign req.cn_rsp_vld = rsp_vld_q;
  assign req.cn_rsp_hit = rsp_hit_q;
  assign req.cn_rsp_tbl = rsp_tbl_q;

  // State, table status mirror and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_w_i;
      empty_q  <= empty_w_i;
      starve_q <= starve_d;
    end
  end

  // Cancel response captured from the table one cycle after the grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_tbl_q <= '0;
    end else begin
      rsp_vld_q <= gnt_cn;
      rsp_hit_q <= gnt_cn && cancel_hit_w_i;
      rsp_tbl_q <= (gnt_cn && cancel_hit_w_i) ? cancel_hit_tbl_w_i : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ob_mk_table_sched.sv
// ============================================================================
//  tb_ob_mk_table_sched
//  Directed bench: a behavioural 16-entry table sits on the table pins, a
//  scoreboard queue holds the expected grant/response/flush events and a
//  negedge monitor pops and compares them as the scheduler produces them.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ob_mk_table_sched;
  localparam int UID_W = 8;
  localparam int TBL_W = 40;
  localparam int DEPTH = 16;
  localparam int STARVE_MAX = 2;

  localparam logic [3:0] K_POP = 4'd0, K_PUSH = 4'd1, K_UPT = 4'd2, K_INS = 4'd3,
                         K_CAN = 4'd4, K_RSP = 4'd5, K_DONE = 4'd6, K_FPOP = 4'd7,
                         K_BAD = 4'd8;

  typedef struct packed {
    logic [3:0]       kind;
    logic             hit;
    logic [TBL_W-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic flush_req, flush_busy, flush_done;
  logic head_pop, head_push, head_upt, insert, cancel;
  logic [TBL_W-1:0] head_push_tbl, head_upt_tbl, insert_tbl;
  logic [UID_W-1:0] cancel_uid;
  logic cancel_hit_w, full_w, empty_w;
  logic [TBL_W-1:0] cancel_hit_tbl_w;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  ob_mk_table_sched_if #(.UID_W(UID_W), .TBL_W(TBL_W)) bus ();

  ob_mk_table_sched #(.STARVE_MAX(STARVE_MAX), .UID_W(UID_W), .TBL_W(TBL_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (bus.slave),
    .flush_req_i        (flush_req),
    .flush_busy_o       (flush_busy),
    .flush_done_o       (flush_done),
    .head_pop_o         (head_pop),
    .head_push_o        (head_push),
    .head_push_tbl_o    (head_push_tbl),
    .head_upt_o         (head_upt),
    .head_upt_tbl_o     (head_upt_tbl),
    .insert_o           (insert),
    .insert_tbl_o       (insert_tbl),
    .cancel_o           (cancel),
    .cancel_uid_o       (cancel_uid),
    .cancel_hit_w_i     (cancel_hit_w),
    .cancel_hit_tbl_w_i (cancel_hit_tbl_w),
    .full_w_i           (full_w),
    .empty_w_i          (empty_w)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural table ----------------
  logic [TBL_W-1:0] mem_q [DEPTH];
  logic [TBL_W-1:0] mem_d [DEPTH];
  int               cnt_q, cnt_d;
  logic             m_found;
  logic [TBL_W-1:0] m_tbl;
  int               m_idx;

  always_comb begin
    m_found = 1'b0;
    m_tbl   = '0;
    m_idx   = 0;
    for (int i = 0; i < DEPTH; i++)
      if (!m_found && i < cnt_q && mem_q[i][TBL_W-1 -: UID_W] == cancel_uid) begin
        m_found = 1'b1;
        m_tbl   = mem_q[i];
        m_idx   = i;
      end
  end

  assign cancel_hit_w     = cancel && m_found;
  assign cancel_hit_tbl_w = (cancel && m_found) ? m_tbl : '0;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (head_pop && cnt_q > 0) begin
      for (int i = 0; i < DEPTH-1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - 1;
    end else if (head_push && cnt_q < DEPTH) begin
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      mem_d[0] = head_push_tbl;
      cnt_d = cnt_q + 1;
    end else if (head_upt && cnt_q > 0) begin
      mem_d[0] = head_upt_tbl;
    end else if (insert && cnt_q < DEPTH) begin
      mem_d[cnt_q[3:0]] = insert_tbl;
      cnt_d = cnt_q + 1;
    end else if (cancel_hit_w) begin
      for (int i = 0; i < DEPTH-1; i++) if (i >= m_idx) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - 1;
    end
  end

  assign full_w  = (cnt_d == DEPTH);
  assign empty_w = (cnt_d == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [TBL_W-1:0] mk(input logic [7:0] uid);
    return {uid, 8'hA5, uid ^ 8'h3C, 16'h1000 + {8'h00, uid}};
  endfunction

  function automatic ev_t ev(input logic [3:0] k, input logic h, input logic [TBL_W-1:0] d);
    ev_t e;
    e.kind = k;
    e.hit  = h;
    e.data = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic mon_ev(input ev_t o);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d data %0h, required no event", o.kind, o.data);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard_event", 64'(o), 64'(e));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ev_t o;
    int  npin, nrdy;
    if (!rst) begin
      if (bus.cn_rsp_vld) mon_ev(ev(K_RSP, bus.cn_rsp_hit, bus.cn_rsp_tbl));
      npin = int'(head_pop) + int'(head_push) + int'(head_upt) + int'(insert) + int'(cancel);
      nrdy = int'(bus.hd_req_rdy) + int'(bus.cn_req_rdy) + int'(bus.in_req_rdy);
      if (npin != 0 || nrdy != 0) begin
        o = ev(K_BAD, 1'b0, {35'd0, head_pop, head_push, head_upt, insert, cancel});
        if (npin == 1 && nrdy == 0 && head_pop)                    o = ev(K_FPOP, 1'b0, '0);
        else if (npin == 1 && nrdy == 1 && bus.hd_req_rdy && head_pop)  o = ev(K_POP, 1'b0, '0);
        else if (npin == 1 && nrdy == 1 && bus.hd_req_rdy && head_push) o = ev(K_PUSH, 1'b0, head_push_tbl);
        else if (npin == 1 && nrdy == 1 && bus.hd_req_rdy && head_upt)  o = ev(K_UPT, 1'b0, head_upt_tbl);
        else if (npin == 1 && nrdy == 1 && bus.in_req_rdy && insert)    o = ev(K_INS, 1'b0, insert_tbl);
        else if (npin == 1 && nrdy == 1 && bus.cn_req_rdy && cancel)
          o = ev(K_CAN, 1'b0, {{(TBL_W-UID_W){1'b0}}, cancel_uid});
        mon_ev(o);
      end
      if (flush_done) mon_ev(ev(K_DONE, 1'b0, '0));
      check("idle_payload_zero",
            ((head_push || head_push_tbl == '0) && (head_upt || head_upt_tbl == '0) &&
             (insert || insert_tbl == '0) && (cancel || cancel_uid == '0)), 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int which);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if ((which == 0 && bus.hd_req_rdy) || (which == 1 && bus.cn_req_rdy) ||
          (which == 2 && bus.in_req_rdy)) break;
      t++;
      if (t >= 50) begin
        n_checks++;
        $display("FAIL grant_timeout: requester %0d got no rdy in 50 cycles, required rdy", which);
        break;
      end
    end
  endtask

  task automatic issue_ins(input logic [7:0] uid);
    exp_q.push_back(ev(K_INS, 1'b0, mk(uid)));
    bus.in_req_vld = 1'b1;
    bus.in_req_tbl = mk(uid);
    wait_rdy(2);
    cyc();
    bus.in_req_vld = 1'b0;
    bus.in_req_tbl = '0;
  endtask

  task automatic issue_can(input logic [7:0] uid, input logic hit, input logic [TBL_W-1:0] tbl);
    exp_q.push_back(ev(K_CAN, 1'b0, {{(TBL_W-UID_W){1'b0}}, uid}));
    exp_q.push_back(ev(K_RSP, hit, tbl));
    bus.cn_req_vld = 1'b1;
    bus.cn_req_uid = uid;
    wait_rdy(1);
    cyc();
    bus.cn_req_vld = 1'b0;
    bus.cn_req_uid = '0;
    @(negedge clk);
    check("cn_rsp_next_cycle", bus.cn_rsp_vld, 1'b1);
    cyc();
  endtask

  task automatic flush_run(input int n, input bit hold_ins, input logic [7:0] uid);
    flush_req = 1'b1;
    @(negedge clk);
    check("flush_idle_before", flush_busy, 1'b0);
    cyc();
    flush_req = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back(ev(K_FPOP, 1'b0, '0));
    exp_q.push_back(ev(K_DONE, 1'b0, '0));
    if (hold_ins) begin
      bus.in_req_vld = 1'b1;
      bus.in_req_tbl = mk(uid);
      exp_q.push_back(ev(K_INS, 1'b0, mk(uid)));
    end
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      check("flush_pop", head_pop, (c < n));
      check("flush_done", flush_done, (c == n + 1));
      check("flush_busy", flush_busy, 1'b1);
      check("flush_stall", {bus.hd_req_rdy, bus.cn_req_rdy, bus.in_req_rdy}, 3'b000);
      cyc();
    end
    @(negedge clk);
    check("flush_exit", {flush_busy, flush_done}, 2'b00);
    if (hold_ins) check("flush_ins_resume", bus.in_req_rdy, 1'b1);
    cyc();
    bus.in_req_vld = 1'b0;
    bus.in_req_tbl = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush_req = 1'b0;
    bus.hd_req_vld = 1'b0; bus.hd_req_op = 2'd0; bus.hd_req_tbl = '0;
    bus.cn_req_vld = 1'b0; bus.cn_req_uid = '0;
    bus.in_req_vld = 1'b0; bus.in_req_tbl = '0;
    cyc();
    // requests during reset must see no grant and no table pin
    bus.hd_req_vld = 1'b1; bus.hd_req_op = 2'd1; bus.hd_req_tbl = mk(8'h44);
    bus.cn_req_vld = 1'b1; bus.cn_req_uid = 8'h44;
    bus.in_req_vld = 1'b1; bus.in_req_tbl = mk(8'h99);
    @(negedge clk);
    check("rst_rdy", {bus.hd_req_rdy, bus.cn_req_rdy, bus.in_req_rdy}, 3'b000);
    check("rst_pins", {head_pop, head_push, head_upt, insert, cancel}, 5'b00000);
    check("rst_status", {bus.cn_rsp_vld, flush_busy, flush_done}, 3'b000);
    cyc();
    bus.hd_req_vld = 1'b0; bus.cn_req_vld = 1'b0; bus.in_req_vld = 1'b0;
    bus.hd_req_tbl = '0; bus.cn_req_uid = '0; bus.in_req_tbl = '0; bus.hd_req_op = 2'd0;
    cyc();
    rst = 1'b0;
    cyc();

    // three back-to-back inserts
    for (int i = 0; i < 3; i++) begin
      bus.in_req_vld = 1'b1;
      bus.in_req_tbl = mk(8'(i + 1));
      exp_q.push_back(ev(K_INS, 1'b0, mk(8'(i + 1))));
      @(negedge clk);
      check("ins_b2b_rdy", bus.in_req_rdy, 1'b1);
      cyc();
    end
    bus.in_req_vld = 1'b0;
    bus.in_req_tbl = '0;

    // cancel hit and miss
    issue_ins(8'd5);
    issue_can(8'd5, 1'b1, mk(8'd5));
    issue_can(8'd9, 1'b0, '0);

    // head update and insert both held: H, H, I, H
    bus.hd_req_vld = 1'b1; bus.hd_req_op = 2'd2; bus.hd_req_tbl = mk(8'h21);
    bus.in_req_vld = 1'b1; bus.in_req_tbl = mk(8'd10);
    exp_q.push_back(ev(K_UPT, 1'b0, mk(8'h21)));
    exp_q.push_back(ev(K_UPT, 1'b0, mk(8'h21)));
    exp_q.push_back(ev(K_INS, 1'b0, mk(8'd10)));
    exp_q.push_back(ev(K_UPT, 1'b0, mk(8'h21)));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("starve_hd_rdy", bus.hd_req_rdy, (c != 2));
      check("starve_in_rdy", bus.in_req_rdy, (c == 2));
      cyc();
      if (c == 2) begin
        bus.in_req_vld = 1'b0;
        bus.in_req_tbl = '0;
      end
    end
    bus.hd_req_vld = 1'b0; bus.hd_req_tbl = '0;

    // fill to 16, then push/insert blocked until a pop frees a slot
    for (int u = 20; u < 32; u++) issue_ins(8'(u));
    bus.hd_req_vld = 1'b1; bus.hd_req_op = 2'd1; bus.hd_req_tbl = mk(8'h50);
    bus.in_req_vld = 1'b1; bus.in_req_tbl = mk(8'd40);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_stall", {bus.hd_req_rdy, bus.in_req_rdy}, 2'b00);
      cyc();
    end
    bus.hd_req_op = 2'd0; bus.hd_req_tbl = '0;
    exp_q.push_back(ev(K_POP, 1'b0, '0));
    exp_q.push_back(ev(K_INS, 1'b0, mk(8'd40)));
    @(negedge clk);
    check("full_pop_grant", {bus.hd_req_rdy, bus.in_req_rdy}, 2'b10);
    cyc();
    bus.hd_req_vld = 1'b0;
    @(negedge clk);
    check("full_ins_after_pop", bus.in_req_rdy, 1'b1);
    cyc();
    bus.in_req_vld = 1'b0; bus.in_req_tbl = '0;

    // flush a full table, then four entries with an insert waiting
    flush_run(16, 1'b0, 8'd0);
    for (int u = 60; u < 64; u++) issue_ins(8'(u));
    flush_run(4, 1'b1, 8'd70);
    issue_can(8'd70, 1'b1, mk(8'd70));
    flush_run(0, 1'b0, 8'd0);

    // pop on empty never granted; concurrent cancel wins at once
    bus.hd_req_vld = 1'b1; bus.hd_req_op = 2'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("pop_empty_stall", bus.hd_req_rdy, 1'b0);
      cyc();
    end
    exp_q.push_back(ev(K_CAN, 1'b0, {{(TBL_W-UID_W){1'b0}}, 8'd77}));
    exp_q.push_back(ev(K_RSP, 1'b0, '0));
    bus.cn_req_vld = 1'b1; bus.cn_req_uid = 8'd77;
    @(negedge clk);
    check("cancel_beats_blocked_pop", {bus.hd_req_rdy, bus.cn_req_rdy}, 2'b01);
    cyc();
    bus.cn_req_vld = 1'b0; bus.cn_req_uid = '0;
    @(negedge clk);
    check("pop_empty_after_cancel", bus.hd_req_rdy, 1'b0);
    cyc();
    bus.hd_req_vld = 1'b0;

    // reserved op never granted even with entries present
    issue_ins(8'd80);
    bus.hd_req_vld = 1'b1; bus.hd_req_op = 2'd3; bus.hd_req_tbl = mk(8'h33);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("op3_never", bus.hd_req_rdy, 1'b0);
      cyc();
    end
    bus.hd_req_vld = 1'b0; bus.hd_req_op = 2'd0; bus.hd_req_tbl = '0;

    // reset in the middle of a flush: back to RUN, no done pulse
    issue_ins(8'd81);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    exp_q.push_back(ev(K_FPOP, 1'b0, '0));
    @(negedge clk);
    check("rstflush_first_pop", head_pop, 1'b1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rstflush_in_reset", {flush_busy, flush_done, head_pop}, 3'b000);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstflush_no_done", {flush_busy, flush_done}, 2'b00);
      cyc();
    end

    repeat (3) cyc();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
